// File: rtl/bus_bridge_master.sv
// rtl/bus_bridge_master.sv - UART-driven serial bus master: 21-bit frames in on u_rx, bus transactions out, read bytes back on u_tx
module bus_bridge_master #(
    parameter int ADDR_WIDTH           = 16,
    parameter int DATA_WIDTH           = 8,
    parameter int SLAVE_MEM_ADDR_WIDTH = 12,
    parameter int BB_ADDR_WIDTH        = 12,
    parameter int CLOCKS_PER_PULSE     = 5208
) (
    input  logic clk,
    input  logic rstn,
    input  logic mrdata,
    output logic mwdata,
    output logic mmode,
    output logic mvalid,
    input  logic svalid,
    output logic mbreq,
    input  logic mbgrant,
    input  logic ack,
    input  logic msplit,
    output logic u_tx,
    input  logic u_rx
);
    localparam int FRAME_W = 1 + DATA_WIDTH + BB_ADDR_WIDTH;
    localparam int CNT_W   = $clog2(CLOCKS_PER_PULSE) + 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [4:0]       RX_STOP   = 5'(FRAME_W + 1);

    typedef enum logic [2:0] {
        IDLE, REQ, DEVADDR, WAIT_ACK, MEMADDR, WDATA, RDATA, DONE
    } state_t;

    state_t state, state_next;
    logic [3:0] cnt;
    logic [FRAME_W-1:0] frame;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic rd_pending;
    logic tx_start, tx_busy;

    // UART receiver: rx_bit 0 is the start bit, 1..FRAME_W data, FRAME_W+1 stop
    logic rx_meta, rx_s, rx_busy, frame_done;
    logic [CNT_W-1:0] rx_cnt;
    logic [4:0] rx_bit;
    logic [FRAME_W-1:0] rx_shift;

    always_ff @(posedge clk) begin
        if (rstn) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_busy    <= 1'b0;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            frame_done <= 1'b0;
        end else begin
            rx_meta    <= u_rx;
            rx_s       <= rx_meta;
            frame_done <= 1'b0;
            if (!rx_busy) begin
                rx_cnt  <= '0;
                rx_bit  <= '0;
                rx_busy <= ~rx_s;
            end else if (rx_bit == 5'd0) begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt <= '0;
                    if (rx_s) rx_busy <= 1'b0;
                    else      rx_bit  <= 5'd1;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
            end else if (rx_cnt == BIT_LAST) begin
                rx_cnt <= '0;
                if (rx_bit == RX_STOP) begin
                    rx_busy    <= 1'b0;
                    frame_done <= rx_s;
                end else begin
                    rx_shift <= {rx_s, rx_shift[FRAME_W-1:1]};
                    rx_bit   <= rx_bit + 5'd1;
                end
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

    logic [CNT_W-1:0] tx_cnt;
    logic [3:0] tx_bit;
    logic [DATA_WIDTH:0] tx_shift;

    always_ff @(posedge clk) begin
        if (rstn) begin
            u_tx     <= 1'b1;
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '1;
        end else if (tx_start && !tx_busy) begin
            u_tx     <= 1'b0;
            tx_busy  <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= {1'b1, rd_shift};
        end else if (tx_busy) begin
            if (tx_cnt == BIT_LAST) begin
                tx_cnt <= '0;
                if (tx_bit == 4'(DATA_WIDTH + 1)) begin
                    tx_busy <= 1'b0;
                end else begin
                    u_tx     <= tx_shift[0];
                    tx_shift <= {1'b1, tx_shift[DATA_WIDTH:1]};
                    tx_bit   <= tx_bit + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    logic mode_lat;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BB_ADDR_WIDTH-1:0] bb_addr;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [3:0] dev_bits;
    logic [SLAVE_MEM_ADDR_WIDTH-1:0] mem_addr;
    logic rd_accept;

    assign mode_lat  = frame[FRAME_W-1];
    assign wr_data   = frame[FRAME_W-2 -: DATA_WIDTH];
    assign bb_addr   = frame[BB_ADDR_WIDTH-1:0];
    // Top bridge address bit selects device 0 or 1; memory address keeps bit 11 clear
    assign bus_addr  = {3'b000, bb_addr[BB_ADDR_WIDTH-1], 1'b0, bb_addr[BB_ADDR_WIDTH-2:0]};
    assign dev_bits  = bus_addr[ADDR_WIDTH-1 -: 4];
    assign mem_addr  = bus_addr[SLAVE_MEM_ADDR_WIDTH-1:0];
    assign rd_accept = svalid & ~msplit;

    always_comb begin
        state_next = state;
        mbreq      = 1'b0;
        mvalid     = 1'b0;
        mwdata     = 1'b0;
        mmode      = 1'b0;
        tx_start   = 1'b0;
        case (state)
            IDLE: if (frame_done) state_next = REQ;
            REQ: begin
                mbreq = 1'b1;
                mmode = mode_lat;
                if (mbgrant) state_next = DEVADDR;
            end
            DEVADDR: begin
                mbreq  = 1'b1;
                mmode  = mode_lat;
                mvalid = 1'b1;
                mwdata = dev_bits[cnt[1:0]];
                if (cnt == 4'd3) state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                mbreq = 1'b1;
                mmode = mode_lat;
                if (ack)              state_next = MEMADDR;
                else if (cnt == 4'd7) state_next = DONE;
            end
            MEMADDR: begin
                mbreq  = 1'b1;
                mmode  = mode_lat;
                mvalid = 1'b1;
                mwdata = mem_addr[cnt];
                if (cnt == 4'(SLAVE_MEM_ADDR_WIDTH - 1)) state_next = mode_lat ? WDATA : RDATA;
            end
            WDATA: begin
                mbreq  = 1'b1;
                mmode  = mode_lat;
                mvalid = 1'b1;
                mwdata = wr_data[cnt[2:0]];
                if (cnt == 4'(DATA_WIDTH - 1)) state_next = DONE;
            end
            RDATA: begin
                // mbreq stays up through a split so the bus is re-granted to us
                mbreq = 1'b1;
                mmode = mode_lat;
                if (rd_accept && cnt == 4'(DATA_WIDTH - 1)) state_next = DONE;
            end
            DONE: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                    tx_start   = rd_pending;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            frame      <= '0;
            rd_shift   <= '0;
            rd_pending <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state)              cnt <= '0;
            else if (state != RDATA || rd_accept) cnt <= cnt + 4'd1;
            if (state == IDLE && frame_done) frame <= rx_shift;
            if (state == RDATA && rd_accept) begin
                rd_shift <= {mrdata, rd_shift[DATA_WIDTH-1:1]};
                if (cnt == 4'(DATA_WIDTH - 1)) rd_pending <= 1'b1;
            end
            if (state == DONE && !tx_busy) rd_pending <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bus_bridge_master.sv
// tb/tb_bus_bridge_master.sv - randomized scoreboard bench for bus_bridge_master with bus slave and UART models
module tb_bus_bridge_master;
    localparam int CPP = 16;

    logic clk = 1'b0;
    logic rstn, mrdata, mwdata, mmode, mvalid, svalid, mbreq, mbgrant, ack, msplit, u_tx, u_rx;

    always #5 clk = ~clk;

    bus_bridge_master #(.CLOCKS_PER_PULSE(CPP)) dut (
        .clk(clk), .rstn(rstn), .mrdata(mrdata), .mwdata(mwdata), .mmode(mmode),
        .mvalid(mvalid), .svalid(svalid), .mbreq(mbreq), .mbgrant(mbgrant), .ack(ack),
        .msplit(msplit), .u_tx(u_tx), .u_rx(u_rx)
    );

    typedef struct {
        int         nbits;
        logic       mode;
        logic [3:0] dev;
        logic [11:0] addr;
        logic [7:0] data;
    } bus_txn_t;

    bus_txn_t exp_bus[$];
    logic [7:0] exp_tx[$];
    logic [7:0] ref_mem[logic [15:0]];
    logic [7:0] slave_mem[logic [15:0]];

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int txn_bits = 0;
    int mbreq_cycles = 0;
    int tx_frames = 0;
    bit ack_en = 1'b1;
    bit split_en = 1'b0;
    bit abort_expected = 1'b0;
    bit tx_mon_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Bus slave: collects serial bits, serves read data, optionally splits, scores each transaction
    initial begin : slave
        logic txn_mode, mode_bad, prev_mbreq, serve_pending, serving, split_done;
        logic [3:0] cur_dev;
        logic [11:0] cur_addr;
        logic [7:0] cur_data, rd_byte;
        logic [15:0] k;
        int last_mvalid, serve_idx, split_left, gap;
        bus_txn_t e;
        mbgrant = 1'b0; ack = 1'b0; msplit = 1'b0; svalid = 1'b0; mrdata = 1'b0;
        txn_mode = 1'b0; mode_bad = 1'b0; prev_mbreq = 1'b0; serve_pending = 1'b0;
        serving = 1'b0; split_done = 1'b0; cur_dev = '0; cur_addr = '0; cur_data = '0;
        rd_byte = '0; last_mvalid = 0; serve_idx = 0; split_left = 0;
        forever begin
            @(negedge clk);
            cycle++;
            ack = ack_en;
            msplit = 1'b0;
            svalid = 1'b0;
            if (mbreq) mbreq_cycles++;
            if (serve_pending) begin
                serve_pending = 1'b0; serving = 1'b1; serve_idx = 0; split_done = 1'b0; split_left = 0;
            end
            if (mvalid) begin
                if (txn_bits == 0) txn_mode = mmode;
                else if (mmode !== txn_mode) mode_bad = 1'b1;
                if (txn_bits < 4)       cur_dev[txn_bits] = mwdata;
                else if (txn_bits < 16) cur_addr[txn_bits-4] = mwdata;
                else if (txn_bits < 24) cur_data[txn_bits-16] = mwdata;
                txn_bits++;
                last_mvalid = cycle;
                if (txn_bits == 16 && !txn_mode) begin
                    serve_pending = 1'b1;
                    k = {cur_dev, cur_addr};
                    rd_byte = slave_mem.exists(k) ? slave_mem[k] : init_byte(k);
                end
            end
            if (serving) begin
                if (split_en && !split_done && serve_idx == 4 && split_left == 0) split_left = 50;
                if (split_left > 0) begin
                    msplit = 1'b1;
                    split_left--;
                    if (split_left == 0) begin
                        split_done = 1'b1;
                        check("mbreq_held_in_split", mbreq, 1);
                    end
                end else begin
                    svalid = 1'b1;
                    mrdata = rd_byte[serve_idx];
                    serve_idx++;
                    if (serve_idx == 8) serving = 1'b0;
                end
            end
            mbgrant = mbreq & ~msplit;
            if (prev_mbreq && !mbreq) begin
                if (abort_expected) begin
                    abort_expected = 1'b0;
                end else if (exp_bus.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_bus_txn: got %0d bits, none expected", txn_bits);
                end else begin
                    e = exp_bus.pop_front();
                    check("bus_nbits", txn_bits, e.nbits);
                    check("bus_dev", cur_dev, e.dev);
                    if (e.nbits > 4) begin
                        check("bus_addr", cur_addr, e.addr);
                        check("bus_mmode", {mode_bad, txn_mode}, {1'b0, e.mode});
                    end
                    if (e.nbits == 24) check("bus_wdata", cur_data, e.data);
                    if (e.nbits == 4) begin
                        gap = cycle - last_mvalid;
                        checks++;
                        if (gap < 9 || gap > 10) begin
                            errors++;
                            $display("FAIL noack_mbreq_drop: got %0d clocks expected 9..10", gap);
                        end
                    end
                    if (txn_mode && txn_bits == 24) slave_mem[{cur_dev, cur_addr}] = cur_data;
                end
                txn_bits = 0; mode_bad = 1'b0; serving = 1'b0; serve_pending = 1'b0;
                cur_dev = '0; cur_addr = '0; cur_data = '0;
            end
            prev_mbreq = mbreq;
        end
    end

    // UART TX monitor: decodes u_tx frames at mid-bit
    initial begin : tx_mon
        logic [7:0] b;
        logic stop_bit;
        forever begin
            @(negedge clk);
            if (u_tx === 1'b0) begin
                tx_mon_busy = 1'b1;
                repeat (CPP/2 - 1) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPP) @(negedge clk);
                    b[i] = u_tx;
                end
                repeat (CPP) @(negedge clk);
                stop_bit = u_tx;
                tx_frames++;
                if (exp_tx.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_tx_byte: got 0x%0h, none expected", b);
                end else begin
                    check("tx_byte", b, exp_tx.pop_front());
                    check("tx_stop_bit", stop_bit, 1);
                end
                tx_mon_busy = 1'b0;
            end
        end
    end

    task automatic send_frame(input logic [20:0] f);
        @(negedge clk);
        u_rx = 1'b0;
        repeat (CPP) @(negedge clk);
        for (int i = 0; i < 21; i++) begin
            u_rx = f[i];
            repeat (CPP) @(negedge clk);
        end
        u_rx = 1'b1;
        repeat (CPP) @(negedge clk);
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while ((exp_bus.size() != 0 || exp_tx.size() != 0 || tx_mon_busy) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (exp_bus.size() != 0 || exp_tx.size() != 0) begin
            checks++; errors++;
            $display("FAIL timeout: %0d bus and %0d tx expectations outstanding", exp_bus.size(), exp_tx.size());
            exp_bus.delete();
            exp_tx.delete();
        end
        repeat (20) @(negedge clk);
    endtask

    // Reference model: device = bb/2048, memory offset = bb%2048, bus address = device*4096 + offset
    task automatic issue(input logic mode, input logic [7:0] data, input logic [11:0] bb,
                         input bit do_ack, input bit do_split);
        bus_txn_t e;
        logic [15:0] k;
        k = 16'((int'(bb) / 2048) * 4096 + (int'(bb) % 2048));
        ack_en = do_ack;
        split_en = do_split;
        e.mode = mode; e.dev = k[15:12]; e.addr = k[11:0]; e.data = data;
        e.nbits = !do_ack ? 4 : (mode ? 24 : 16);
        exp_bus.push_back(e);
        if (do_ack) begin
            if (mode) ref_mem[k] = data;
            else      exp_tx.push_back(ref_mem.exists(k) ? ref_mem[k] : init_byte(k));
        end
        send_frame({mode, data, bb});
        wait_quiet();
    endtask

    initial begin : stim
        int n, m0, t0;
        logic [11:0] a;
        logic m;
        logic [7:0] d;
        rstn = 1'b1;
        u_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_mbreq", mbreq, 0);
        check("reset_mvalid", mvalid, 0);
        check("reset_mwdata", mwdata, 0);
        check("reset_mmode", mmode, 0);
        check("reset_u_tx", u_tx, 1);
        rstn = 1'b0;
        repeat (5) @(negedge clk);

        issue(1'b1, 8'hA5, 12'h123, 1'b1, 1'b0);
        issue(1'b0, 8'h00, 12'h123, 1'b1, 1'b0);
        issue(1'b1, 8'h3C, 12'h805, 1'b1, 1'b0);
        issue(1'b0, 8'h00, 12'h805, 1'b1, 1'b1);
        issue(1'b0, 8'h00, 12'h7FF, 1'b1, 1'b0);
        issue(1'b1, 8'h5A, 12'h456, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 12'h123;
                1:       a = 12'h805;
                default: a = 12'($urandom);
            endcase
            m = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            issue(m, d, a, 1'b1, !m && ($urandom_range(0, 1) == 1));
        end

        ack_en = 1'b1;
        split_en = 1'b0;
        abort_expected = 1'b1;
        send_frame({1'b1, 8'h77, 12'h0AA});
        n = 0;
        while (txn_bits < 18 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached_wdata", txn_bits >= 18, 1);
        rstn = 1'b1;
        @(negedge clk);
        check("midreset_mbreq", mbreq, 0);
        check("midreset_mvalid", mvalid, 0);
        check("midreset_u_tx", u_tx, 1);
        rstn = 1'b0;
        m0 = mbreq_cycles;
        t0 = tx_frames;
        repeat (300) @(negedge clk);
        check("post_reset_mbreq_cycles", mbreq_cycles - m0, 0);
        check("post_reset_tx_frames", tx_frames - t0, 0);
        check("leftover_bus", exp_bus.size(), 0);
        check("leftover_tx", exp_tx.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_bridge_master.md
BUS_BRIDGE_MASTER -- requirements
Module: bus_bridge_master

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH (16, bus address bits), DATA_WIDTH (8, data bits), SLAVE_MEM_ADDR_WIDTH (12, slave memory address bits), BB_ADDR_WIDTH (12, bridge address bits), CLOCKS_PER_PULSE (5208, clocks per UART bit).
REQ-002 SHALL have port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-003 SHALL have port rstn, input, 1 bit: reset, synchronous and active-high (asserted = 1).
REQ-004 SHALL have port mrdata, input, 1 bit: serial read data from bus.
REQ-005 SHALL have port mwdata, output, 1 bit: serial address/write data to bus.
REQ-006 SHALL have port mmode, output, 1 bit: 0 = read, 1 = write.
REQ-007 SHALL have port mvalid, output, 1 bit: mwdata bit valid.
REQ-008 SHALL have port svalid, input, 1 bit: mrdata bit valid.
REQ-009 SHALL have port mbreq, output, 1 bit: bus request.
REQ-010 SHALL have port mbgrant, input, 1 bit: bus grant.
REQ-011 SHALL have port ack, input, 1 bit: addressed slave exists and is ready.
REQ-012 SHALL have port msplit, input, 1 bit: transaction split by slave.
REQ-013 SHALL have port u_tx, output, 1 bit: UART transmit line, idle 1.
REQ-014 SHALL have port u_rx, input, 1 bit: UART receive line, idle 1.

Function
REQ-015 UART RX SHALL receive frames of start bit 0, then 21 data bits LSB-first, then stop bit 1, at CLOCKS_PER_PULSE clocks per bit, sampling at mid-bit.
REQ-016 Received 21-bit frame fields SHALL be: [20] mode, [19:12] data, [11:0] bb_addr.
REQ-017 Bus address SHALL be {3'b000, bb_addr[11], 1'b0, bb_addr[10:0]}: device field [15:12] is 0 or 1, memory address [11:0] is {1'b0, bb_addr[10:0]}.
REQ-018 FSM states SHALL be: IDLE, REQ, DEVADDR, WAIT_ACK, MEMADDR, WDATA, RDATA, DONE.
REQ-019 IDLE -> REQ on completed RX frame; the frame SHALL be latched, and frames arriving while not in IDLE SHALL be dropped.
REQ-020 In REQ, mbreq = 1; on mbgrant = 1 -> DEVADDR, with mmode driven from the latched mode until DONE.
REQ-021 In DEVADDR, the 4 device bits SHALL be sent LSB-first, one per clock, with mvalid = 1; then -> WAIT_ACK.
REQ-022 In WAIT_ACK, ack = 1 -> MEMADDR; no ack within 8 clocks -> DONE, transaction discarded, no UART response.
REQ-023 In MEMADDR, 12 bits SHALL be sent LSB-first with mvalid = 1; then write -> WDATA, read -> RDATA.
REQ-024 In WDATA, 8 data bits SHALL be sent LSB-first with mvalid = 1; then -> DONE.
REQ-025 In RDATA, mrdata SHALL be shifted in LSB-first on each svalid = 1 clock; after 8 bits -> DONE and the byte SHALL be handed to UART TX.
REQ-026 While msplit = 1 in RDATA, mbreq SHALL be held and bit reception paused; reception SHALL resume when mbgrant returns and svalid pulses.
REQ-027 DONE SHALL deassert mbreq and mvalid for one clock, then -> IDLE.
REQ-028 mvalid SHALL be 0 in every state other than DEVADDR, MEMADDR and WDATA bit clocks.
REQ-029 UART TX SHALL send start bit 0, then 8 bits LSB-first, then stop bit 1, at CLOCKS_PER_PULSE; a new read byte SHALL NOT be accepted while TX is busy, and the FSM SHALL wait in DONE until TX is idle.

Reset
REQ-030 On rstn = 1 at a clock edge, the block SHALL reset as follows: FSM -> IDLE, mbreq = 0, mvalid = 0, mwdata = 0, mmode = 0, u_tx = 1, UART RX/TX to idle, shift registers cleared.
REQ-031 Reset mid-transaction SHALL abort it with no bus or UART activity after release.

Verification (CLOCKS_PER_PULSE = 16 for simulation)
REQ-032 Write frame {1, 8'hA5, 12'h123} with grant/ack -> device bits 0000, memory address 12'h123, data 8'hA5 serialized LSB-first, mmode = 1.
REQ-033 Read frame {0, x, 12'h123} after REQ-032 against a bus model returning 8'hA5 -> u_tx sends byte A5 LSB-first.
REQ-034 Frame with bb_addr 12'h805 -> device bits 0001, memory address 12'h005.
REQ-035 ack never asserted -> mbreq drops 9-10 clocks after DEVADDR, nothing sent on u_tx.
REQ-036 Read with msplit = 1 for 50 clocks mid-data -> byte still correct after resume.
REQ-037 Reset asserted during WDATA -> mbreq = 0, mvalid = 0, u_tx = 1 on the next edge.
